uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 4..64).
REQ-002 SHALL have parameter BUSY_TMO, default 16, max cycles to wait for tx_state rise after tx_en.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RSTn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_en  input  1  push wr_data into FIFO this cycle.
REQ-006 SHALL have port wr_data  input  8  byte from bus interface.
REQ-007 SHALL have port flush  input  1  discard all queued bytes.
REQ-008 SHALL have port irq_en  input  1  enable tx_irq.
REQ-009 SHALL have port tx_state  input  1  UART transmitter busy (1 = shifting).
REQ-010 SHALL have port tx_en  output  1  one-cycle start pulse to transmitter.
REQ-011 SHALL have port tx_data  output  8  byte presented to transmitter.
REQ-012 SHALL have port full  output  1  FIFO count == DEPTH.
REQ-013 SHALL have port level  output  log2(DEPTH)+1  current FIFO count.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag.
REQ-015 SHALL have port tmo  output  1  sticky busy-timeout flag.
REQ-016 SHALL have port clr_flags  input  1  clears ovf and tmo.
REQ-017 SHALL have port tx_irq  output  1  level interrupt, queue drained.

Function
REQ-018 FIFO SHALL be circular, read/write pointers wrap modulo DEPTH; level = registered count.
REQ-019 Push when count < DEPTH SHALL store byte; push when full without same-cycle pop SHALL drop byte and set ovf.
REQ-020 Push and pop in same cycle SHALL leave count unchanged, accepted even when full.
REQ-021 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE -> LOAD when registered count > 0 and tx_state == 0; pop occurs on this transition, head byte registered into tx_data.
REQ-023 LOAD SHALL assert tx_en for exactly one cycle, then -> WAIT_BUSY.
REQ-024 WAIT_BUSY -> WAIT_DONE when tx_state == 1; after BUSY_TMO cycles without it -> IDLE and set tmo.
REQ-025 WAIT_DONE -> IDLE when tx_state == 0.
REQ-026 Byte pushed into empty FIFO SHALL not pop in the same cycle; earliest tx_en is 2 cycles after push edge.
REQ-027 tx_data SHALL hold its value from LOAD until next pop.
REQ-028 flush SHALL zero count and pointers next edge; in-flight byte (LOAD/WAIT_*) completes normally; flush with same-cycle wr_en: flush wins, byte dropped, ovf unaffected.
REQ-029 flush coincident with IDLE->LOAD SHALL still issue the popped byte.
REQ-030 tx_irq SHALL equal irq_en AND count == 0 AND state == IDLE, registered.
REQ-031 clr_flags SHALL clear ovf/tmo; simultaneous set event SHALL win.

Reset
REQ-032 RSTn low SHALL immediately force state IDLE, count 0, pointers 0, tx_en 0, tx_data 0x00, ovf 0, tmo 0, tx_irq 0, full 0.
REQ-033 Reset mid-transmission SHALL abandon the byte; FIFO contents not preserved.
REQ-034 After RSTn release, no tx_en SHALL occur until a byte is pushed.

Verification
REQ-035 Push 0x41,0x42,0x43 with tx_state model busy 10 cycles per byte -> three tx_en pulses, tx_data 0x41,0x42,0x43 in order, tx_irq rises after third WAIT_DONE exit (irq_en=1).
REQ-036 Hold tx_state=1, push 17 bytes (DEPTH 16) -> full=1, level=16, ovf=1, 17th byte never transmitted.
REQ-037 Full FIFO, transmitter idle, push on pop cycle -> level stays 16, ovf stays 0, all bytes later sent in order.
REQ-038 tx_state stuck 0 after tx_en -> tmo=1 exactly BUSY_TMO cycles after WAIT_BUSY entry, next byte sent; clr_flags clears tmo.
REQ-039 Push 5 bytes, flush during WAIT_DONE of first -> first byte completes, no further tx_en, level=0.
REQ-040 Assert RSTn low during WAIT_DONE with 4 queued -> all outputs at reset values asynchronously, no tx_en after release.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Byte FIFO feeding a UART transmitter: pops one byte at a time and pulses tx_en,
// then waits for the transmitter busy handshake, which can time out.
module uart_tx_sched #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned BUSY_TMO = 16
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     irq_en,
    input  logic                     tx_state,
    input  logic                     clr_flags,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     tmo,
    output logic                     tx_irq
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmoW = $clog2(BUSY_TMO + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TMO - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic              tx_irq_q, tx_irq_d;
    logic [7:0]        mem_q [DEPTH];

    logic pop;
    logic push_req;
    logic push_ok;
    logic ovf_set;
    logic tmo_set;

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        pop       = 1'b0;
        tmo_set   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Decision uses the registered count, so a byte pushed this cycle waits one edge.
                if (count_q != '0 && !tx_state) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                tmo_cnt_d = '0;
                state_d   = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_state) begin
                    state_d = StWaitDone;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_state) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        push_req = wr_en && !flush;
        push_ok  = push_req && ((count_q != DepthC) || pop);
        ovf_set  = push_req && (count_q == DepthC) && !pop;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_d = count_q - 1'b1;
            end
        end

        // A pop coincident with flush still delivers its byte.
        tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
        ovf_d     = ovf_set || (ovf_q && !clr_flags);
        tmo_d     = tmo_set || (tmo_q && !clr_flags);
        tx_irq_d  = irq_en && (count_q == '0) && (state_q == StIdle);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= StIdle;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tmo_cnt_q <= '0;
            tx_data_q <= 8'h00;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            tx_irq_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            tx_irq_q  <= tx_irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_en   = (state_q == StLoad);
    assign tx_data = tx_data_q;
    assign full    = (count_q == DepthC);
    assign level   = count_q;
    assign ovf     = ovf_q;
    assign tmo     = tmo_q;
    assign tx_irq  = tx_irq_q;

endmodule
